mem_access_sequencer: RTL

- Sequences one memory transaction (instruction fetch, data load or data store) on the CPU datapath's MAR/MDR/IR/RAM resources.
- Driven by the main control unit through a req/done handshake.
- Generates the datapath's memory-side enables, runs the MFA/MFC handshake with the RAM, and flags a timeout when the RAM never answers.
- The control unit keeps ownership of ALU, register-file and shifter selects; it reads `phase` to know what the ALU output must hold.

---
 rtl/mem_access_sequencer_if.sv | 28 ++
 rtl/mem_access_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/mem_access_sequencer_if.sv
// Control-unit handshake and RAM/datapath memory-side signals of the memory access sequencer.
// master = control unit + RAM side, slave = the sequencer.
interface mem_access_sequencer_if;
    logic       req;
    logic [1:0] op;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] phase;
    logic       MFC;
    logic       MFA;
    logic       RW_RAM;
    logic       MAR_EN;
    logic       MDR_EN;
    logic       IR_EN;
    logic       SMA;
    logic       SGN_EN;

    modport master (
        output req, op, MFC,
        input  busy, done, err, phase, MFA, RW_RAM, MAR_EN, MDR_EN, IR_EN, SMA, SGN_EN
    );

    modport slave (
        input  req, op, MFC,
        output busy, done, err, phase, MFA, RW_RAM, MAR_EN, MDR_EN, IR_EN, SMA, SGN_EN
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Sequences one fetch/load/store over MAR/MDR/IR and the RAM MFA/MFC handshake.
// All outputs are Moore-decoded from the registered state and latched op.
module mem_access_sequencer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic                   CLK,
    input  logic                   CLR,
    mem_access_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_MAR, S_MDR, S_WAIT, S_LATCH, S_DONE, S_ERR
    } state_t;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    // WAIT is left on the cycle whose count equals the last allowed value,
    // so WAIT lasts exactly TIMEOUT_CYCLES cycles when MFC never comes.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= S_IDLE;
            op_q  <= OP_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.req)
                op_q <= bus.op;
            // Held at zero outside WAIT, so it is clear on every WAIT entry.
            if (state != S_WAIT)
                cnt <= '0;
            else if (!bus.MFC)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.req)
                    state_nxt = (bus.op == OP_ILL) ? S_ERR : S_MAR;
            end
            S_MAR:   state_nxt = (op_q == OP_STORE) ? S_MDR : S_WAIT;
            S_MDR:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.MFC)
                    state_nxt = (op_q == OP_STORE) ? S_DONE : S_LATCH;
                else if (cnt == CNT_LAST)
                    state_nxt = S_ERR;
            end
            S_LATCH: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (state != S_IDLE);
        bus.done   = 1'b0;
        bus.err    = 1'b0;
        bus.phase  = 2'b00;
        bus.MFA    = 1'b0;
        bus.RW_RAM = 1'b1;
        bus.MAR_EN = 1'b0;
        bus.MDR_EN = 1'b0;
        bus.IR_EN  = 1'b0;
        bus.SMA    = 1'b0;
        bus.SGN_EN = 1'b0;
        case (state)
            S_MAR: begin
                bus.phase  = 2'b01;
                bus.MAR_EN = 1'b1;
            end
            S_MDR: begin
                bus.phase  = 2'b10;
                bus.MDR_EN = 1'b1;
            end
            S_WAIT: begin
                bus.MFA    = 1'b1;
                bus.RW_RAM = (op_q != OP_STORE);
            end
            S_LATCH: begin
                bus.MFA = 1'b1;
                if (op_q == OP_FETCH) begin
                    bus.IR_EN = 1'b1;
                end else if (op_q == OP_LOAD) begin
                    bus.MDR_EN = 1'b1;
                    bus.SMA    = 1'b1;
                    bus.SGN_EN = 1'b1;
                end
            end
            S_DONE: bus.done = 1'b1;
            S_ERR: begin
                bus.done = 1'b1;
                bus.err  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
